// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for the 4x decimating polyphase CIC filter: phase strobes,
// filter reset during idle/flush, warm-up discard and a one-deep output register.
module cic_decim_ctrl #(
  parameter int BW        = 11,
  parameter int OW        = BW + 4,
  parameter int FLUSH_CYC = 4,
  parameter int WARMUP    = 8
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 EN,
  input  logic signed [OW-1:0] CIC_OUT,
  input  logic                 OUT_RDY,
  input  logic                 OVF_CLR,
  output logic                 CIC_RES,
  output logic                 EN_2,
  output logic                 EN_4,
  output logic [1:0]           PH,
  output logic signed [OW-1:0] OUT,
  output logic                 OUT_VLD,
  output logic                 OVF,
  output logic [1:0]           STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_WARM  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);
  localparam logic [7:0] WARM_LAST  = 8'(WARMUP - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] flush_cnt;
  logic [7:0] strobe_cnt;
  logic       active;
  logic       flush_done;
  logic       warm_done;
  logic       capture;
  logic       drop;

  assign flush_done = (flush_cnt == FLUSH_LAST);
  assign warm_done  = EN_4 && (strobe_cnt == WARM_LAST);

  // State register
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; EN low pulls every active state back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (EN) state_nxt = S_FLUSH;
      S_FLUSH: begin
        if (!EN)             state_nxt = S_IDLE;
        else if (flush_done) state_nxt = (WARMUP > 0) ? S_WARM : S_RUN;
      end
      S_WARM: begin
        if (!EN)            state_nxt = S_IDLE;
        else if (warm_done) state_nxt = S_RUN;
      end
      S_RUN:   if (!EN) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state and phase
  always_comb begin
    active  = (state == S_WARM) || (state == S_RUN);
    CIC_RES = active;
    EN_2    = active && PH[0];
    EN_4    = active && (PH == 2'd3);
    STATE   = state;
  end

  // Flush counter sits at zero outside FLUSH, so every entry starts a fresh count
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      flush_cnt <= '0;
    end else if (state == S_FLUSH) begin
      flush_cnt <= flush_cnt + 4'd1;
    end else begin
      flush_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      strobe_cnt <= '0;
    end else if (state == S_WARM) begin
      if (EN_4) strobe_cnt <= strobe_cnt + 8'd1;
    end else begin
      strobe_cnt <= '0;
    end
  end

  // Phase runs continuously through WARM and RUN; it only rests in IDLE/FLUSH
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      PH <= '0;
    end else if (active && EN) begin
      PH <= PH + 2'd1;
    end else begin
      PH <= '0;
    end
  end

  // Handshake: a sample moves downstream at an edge where OUT_VLD and OUT_RDY
  // are both 1; while OUT_VLD=1 and OUT_RDY=0 the OUT register is frozen.
  assign capture = (state == S_RUN) && EN && EN_4;
  assign drop    = capture && OUT_VLD && !OUT_RDY;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      OUT     <= '0;
      OUT_VLD <= 1'b0;
    end else if (state != S_IDLE && !EN) begin
      OUT_VLD <= 1'b0;
    end else if (capture && !drop) begin
      OUT     <= CIC_OUT;
      OUT_VLD <= 1'b1;
    end else if (OUT_VLD && OUT_RDY) begin
      OUT_VLD <= 1'b0;
    end
  end

  // Set has priority over clear so a drop on a clear cycle is never lost
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      OVF <= 1'b0;
    end else if (drop) begin
      OVF <= 1'b1;
    end else if (OVF_CLR) begin
      OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Bench for cic_decim_ctrl: two instances (default and FLUSH_CYC=1/WARMUP=0) share
// stimulus and are compared every cycle against a timeline-based reference model.
module tb_cic_decim_ctrl;

  localparam int OW  = 15;
  localparam int FC0 = 4;
  localparam int WU0 = 8;
  localparam int FC1 = 1;
  localparam int WU1 = 0;

  logic          CLK;
  logic          RES;
  logic          EN;
  logic [OW-1:0] CIC_OUT;
  logic          OUT_RDY;
  logic          OVF_CLR;

  logic [1:0]    cres_o;
  logic [1:0]    en2_o;
  logic [1:0]    en4_o;
  logic [1:0]    vld_o;
  logic [1:0]    ovf_o;
  logic [1:0]    ph_o  [2];
  logic [1:0]    st_o  [2];
  logic [OW-1:0] out_o [2];

  int checks = 0;
  int errors = 0;

  // Reference model: position on the enable timeline plus output register contents
  bit            m_on  [2];
  int            m_k   [2];
  logic          m_vld [2];
  logic [OW-1:0] m_out [2];
  logic          m_ovf [2];

  bit            ramp_mode = 1'b0;
  logic [OW-1:0] ramp = '0;

  cic_decim_ctrl #(.BW(11), .OW(OW), .FLUSH_CYC(FC0), .WARMUP(WU0)) u0 (
    .CLK(CLK), .RES(RES), .EN(EN), .CIC_OUT(CIC_OUT), .OUT_RDY(OUT_RDY),
    .OVF_CLR(OVF_CLR), .CIC_RES(cres_o[0]), .EN_2(en2_o[0]), .EN_4(en4_o[0]),
    .PH(ph_o[0]), .OUT(out_o[0]), .OUT_VLD(vld_o[0]), .OVF(ovf_o[0]),
    .STATE(st_o[0])
  );

  cic_decim_ctrl #(.BW(11), .OW(OW), .FLUSH_CYC(FC1), .WARMUP(WU1)) u1 (
    .CLK(CLK), .RES(RES), .EN(EN), .CIC_OUT(CIC_OUT), .OUT_RDY(OUT_RDY),
    .OVF_CLR(OVF_CLR), .CIC_RES(cres_o[1]), .EN_2(en2_o[1]), .EN_4(en4_o[1]),
    .PH(ph_o[1]), .OUT(out_o[1]), .OUT_VLD(vld_o[1]), .OVF(ovf_o[1]),
    .STATE(st_o[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int fc(input int i);
    return (i == 0) ? FC0 : FC1;
  endfunction

  function automatic int wu(input int i);
    return (i == 0) ? WU0 : WU1;
  endfunction

  // Cycle k after the enabling edge: FLUSH for fc cycles, then 4*wu WARM cycles, then RUN
  function automatic int exp_state(input int i);
    if (!m_on[i]) return 0;
    if (m_k[i] < fc(i)) return 1;
    if (m_k[i] - fc(i) < 4 * wu(i)) return 2;
    return 3;
  endfunction

  function automatic int exp_ph(input int i);
    if (exp_state(i) < 2) return 0;
    return (m_k[i] - fc(i)) % 4;
  endfunction

  function automatic int exp_en4(input int i);
    return (exp_state(i) >= 2 && exp_ph(i) == 3) ? 1 : 0;
  endfunction

  function automatic int exp_en2(input int i);
    return (exp_state(i) >= 2 && (exp_ph(i) % 2) == 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_on[i]  = 1'b0;
      m_k[i]   = 0;
      m_vld[i] = 1'b0;
      m_out[i] = '0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int  st;
    int  e4;
    bit  cap;
    bit  drp;
    for (int i = 0; i < 2; i++) begin
      st  = exp_state(i);
      e4  = exp_en4(i);
      cap = 1'b0;
      drp = 1'b0;
      if (!m_on[i]) begin
        if (EN) begin
          m_on[i] = 1'b1;
          m_k[i]  = 0;
        end
      end else if (!EN) begin
        m_on[i]  = 1'b0;
        m_vld[i] = 1'b0;
      end else begin
        cap = (st == 3) && (e4 == 1);
        drp = cap && m_vld[i] && !OUT_RDY;
        if (cap && !drp) begin
          m_out[i] = CIC_OUT;
          m_vld[i] = 1'b1;
        end else if (m_vld[i] && OUT_RDY) begin
          m_vld[i] = 1'b0;
        end
        m_k[i] = m_k[i] + 1;
      end
      if (drp) m_ovf[i] = 1'b1;
      else if (OVF_CLR) m_ovf[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_state", i),   32'(st_o[i]),  32'(exp_state(i)));
      chk($sformatf("u%0d_ph", i),      32'(ph_o[i]),  32'(exp_ph(i)));
      chk($sformatf("u%0d_cic_res", i), 32'(cres_o[i]), 32'(exp_state(i) >= 2));
      chk($sformatf("u%0d_en_2", i),    32'(en2_o[i]), 32'(exp_en2(i)));
      chk($sformatf("u%0d_en_4", i),    32'(en4_o[i]), 32'(exp_en4(i)));
      chk($sformatf("u%0d_out_vld", i), 32'(vld_o[i]), 32'(m_vld[i]));
      chk($sformatf("u%0d_out", i),     32'(out_o[i]), 32'(m_out[i]));
      chk($sformatf("u%0d_ovf", i),     32'(ovf_o[i]), 32'(m_ovf[i]));
    end
  endtask

  // One clock: present data, take the edge, advance the model, check 1 ns later
  task automatic step();
    int e4;
    if (ramp_mode) CIC_OUT = ramp;
    else           CIC_OUT = OW'($urandom);
    e4 = exp_en4(0);
    @(posedge CLK);
    if (!RES) model_reset();
    else      model_edge();
    if (ramp_mode && e4 == 1) ramp = ramp + 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    RES     = 1'b0;
    EN      = 1'b0;
    OUT_RDY = 1'b0;
    OVF_CLR = 1'b0;
    CIC_OUT = '0;
    model_reset();
    repeat (2) step();

    // Start-up timing and ramp transfer with a always-ready consumer
    RES       = 1'b1;
    EN        = 1'b1;
    OUT_RDY   = 1'b1;
    ramp_mode = 1'b1;
    repeat (60) step();

    // Stall across two strobes, then drain and clear
    OUT_RDY = 1'b0;
    repeat (9) step();
    OUT_RDY = 1'b1;
    repeat (2) step();
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    step();

    // Clear held through a drop: set must win on the drop edge
    OUT_RDY = 1'b0;
    OVF_CLR = 1'b1;
    repeat (9) step();
    OVF_CLR = 1'b0;
    OUT_RDY = 1'b1;
    repeat (4) step();

    // Randomized consumer, clear and occasional disable
    ramp_mode = 1'b0;
    for (int n = 0; n < 150; n++) begin
      EN      = ($urandom_range(0, 40) != 0);
      OUT_RDY = 1'($urandom_range(0, 1));
      OVF_CLR = EN && ($urandom_range(0, 7) == 0);
      step();
    end

    // Disable mid-RUN, re-enable, disable mid-WARM, full restart
    EN      = 1'b1;
    OVF_CLR = 1'b0;
    OUT_RDY = 1'b1;
    repeat (40) step();
    EN = 1'b0;
    step();
    EN = 1'b1;
    repeat (20) step();
    EN = 1'b0;
    step();
    EN = 1'b1;
    for (int n = 0; n < 50; n++) begin
      OUT_RDY = 1'($urandom_range(0, 1));
      step();
    end

    // Asynchronous reset pulse between clock edges
    #1 RES = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 RES = 1'b1;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
